// File: rtl/matrix_uart_input_parser_if.sv
// Write channel from the UART matrix parser to multi_matrix_storage.
interface matrix_uart_input_parser_if #(
    parameter int unsigned DATA_WIDTH = 9
);
    logic                        wr_en;
    logic                        wr_ready;
    logic [2:0]                  wr_row;
    logic [2:0]                  wr_col;
    logic [25*DATA_WIDTH-1:0]    wr_data;

    modport master (output wr_en, wr_row, wr_col, wr_data, input wr_ready);
    modport slave  (input wr_en, wr_row, wr_col, wr_data, output wr_ready);
endinterface

// File: rtl/matrix_uart_input_parser.sv
// Parses "<rows> <cols> <e0> ..." ASCII text into one matrix write request.
// Optional byte echo to the UART transmitter: define MATRIX_PARSER_ECHO_EN.
module matrix_uart_input_parser #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned MAX_DIM    = 5,
    parameter int unsigned ELEM_MAX   = (1 << DATA_WIDTH) - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    matrix_uart_input_parser_if.master wr,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy
);
    localparam int unsigned ACC_W  = DATA_WIDTH + 4;
    localparam int unsigned ACC_WW = ACC_W + 4;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [2:0] {IDLE, GET_ROW, GET_COL, GET_ELEM, COMMIT} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic              has_digit;
    logic [4:0]        elem_idx;

    logic              is_digit;
    logic              is_sep;
    logic [3:0]        digit;
    logic [ACC_WW-1:0] acc_wide;
    logic [ACC_W-1:0]  acc_next;
    logic              token_end;
    logic              dim_ok;
    logic              elem_ok;
    logic [5:0]        elem_total;
    logic              last_elem;
    logic [1:0]        fault_code;

    // Byte classification, saturating accumulator and token-level checks
    always_comb begin
        is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_sep     = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
        digit      = rx_data[3:0];
        acc_wide   = ACC_WW'(acc) * ACC_WW'(10) + ACC_WW'(digit);
        acc_next   = (acc_wide > ACC_WW'(ACC_MAX)) ? ACC_MAX : acc_wide[ACC_W-1:0];
        token_end  = rx_valid && is_sep && has_digit;
        dim_ok     = (acc >= ACC_W'(1)) && (acc <= ACC_W'(MAX_DIM));
        elem_ok    = (acc <= ACC_W'(ELEM_MAX));
        elem_total = 6'(wr.wr_row) * 6'(wr.wr_col);
        last_elem  = (6'(elem_idx) + 6'd1) == elem_total;
        fault_code = 2'd0;
        if ((state == GET_ROW || state == GET_COL || state == GET_ELEM) && enable && rx_valid) begin
            if (!is_digit && !is_sep)
                fault_code = 2'd3;
            else if (token_end && state != GET_ELEM && !dim_ok)
                fault_code = 2'd1;
            else if (token_end && state == GET_ELEM && !elem_ok)
                fault_code = 2'd2;
        end
    end

    // Parser FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            has_digit  <= 1'b0;
            elem_idx   <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            wr.wr_en   <= 1'b0;
            wr.wr_row  <= '0;
            wr.wr_col  <= '0;
            wr.wr_data <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && rx_valid && is_digit) begin
                        wr.wr_data <= '0;
                        err_code   <= 2'd0;
                        busy       <= 1'b1;
                        acc        <= ACC_W'(digit);
                        has_digit  <= 1'b1;
                        elem_idx   <= '0;
                        state      <= GET_ROW;
                    end
                end
                COMMIT: begin
                    // Incoming bytes are dropped until the storage takes the matrix
                    if (wr.wr_ready || !enable) begin
                        wr.wr_en <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    if (!enable) begin
                        busy      <= 1'b0;
                        acc       <= '0;
                        has_digit <= 1'b0;
                        state     <= IDLE;
                    end else if (fault_code != 2'd0) begin
                        err       <= 1'b1;
                        err_code  <= fault_code;
                        busy      <= 1'b0;
                        acc       <= '0;
                        has_digit <= 1'b0;
                        state     <= IDLE;
                    end else if (rx_valid && is_digit) begin
                        acc       <= acc_next;
                        has_digit <= 1'b1;
                    end else if (token_end) begin
                        acc       <= '0;
                        has_digit <= 1'b0;
                        case (state)
                            GET_ROW: begin
                                wr.wr_row <= acc[2:0];
                                state     <= GET_COL;
                            end
                            GET_COL: begin
                                wr.wr_col <= acc[2:0];
                                state     <= GET_ELEM;
                            end
                            default: begin
                                wr.wr_data[32'(elem_idx)*DATA_WIDTH +: DATA_WIDTH] <= acc[DATA_WIDTH-1:0];
                                elem_idx <= elem_idx + 5'd1;
                                if (last_elem) begin
                                    wr.wr_en <= 1'b1;
                                    state    <= COMMIT;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef MATRIX_PARSER_ECHO_EN
    logic       hold_full;
    logic [7:0] hold_byte;

    // One-byte echo buffer; bytes arriving while it is full are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_byte <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (hold_full && !tx_busy && !tx_start) begin
                tx_data   <= hold_byte;
                tx_start  <= 1'b1;
                hold_full <= 1'b0;
            end else if (rx_valid && !hold_full) begin
                hold_byte <= rx_data;
                hold_full <= 1'b1;
            end
        end
    end
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data        = '0;
    assign tx_start       = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_uart_input_parser.sv
// Randomized bench for matrix_uart_input_parser against a token-level text model.
module tb_matrix_uart_input_parser;
    localparam int unsigned DW = 9;
    localparam int unsigned DB = 25 * DW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic       busy, err, tx_start;
    logic [1:0] err_code;
    logic [7:0] tx_data;

    matrix_uart_input_parser_if #(.DATA_WIDTH(DW)) wr_if ();

    matrix_uart_input_parser #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr(wr_if), .busy(busy), .err(err), .err_code(err_code),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Text-level model: tokens, dimensions and a slot array
    bit m_active, m_commit, m_has;
    int m_cur, m_tok, m_rows, m_cols, m_writes;
    int m_data [25];
    bit e_wr_en, e_busy, e_err, e_tx_start;
    int e_code, e_row, e_col, e_tx_data;
    bit h_full;
    int h_byte;

    task automatic model_reset();
        m_active = 0; m_commit = 0; m_has = 0; m_cur = 0; m_tok = 0;
        m_rows = 0; m_cols = 0;
        foreach (m_data[k]) m_data[k] = 0;
        e_wr_en = 0; e_busy = 0; e_err = 0; e_code = 0; e_row = 0; e_col = 0;
        e_tx_start = 0; e_tx_data = 0; h_full = 0; h_byte = 0;
    endtask

    task automatic model_fail(input int c);
        e_err = 1; e_code = c; e_busy = 0; m_active = 0; m_has = 0;
    endtask

    task automatic model_token(input int v);
        if (m_tok < 2) begin
            if (v < 1 || v > 5) model_fail(1);
            else begin
                if (m_tok == 0) m_rows = v; else m_cols = v;
                m_tok++;
            end
        end else if (v > 511) begin
            model_fail(2);
        end else begin
            m_data[m_tok-2] = v;
            m_tok++;
            if (m_tok - 2 == m_rows * m_cols) begin
                m_active = 0; m_commit = 1; e_wr_en = 1; e_row = m_rows; e_col = m_cols;
            end
        end
    endtask

    task automatic model_step();
        int b;
        bit rv, dig, sep, old_full;
        b = int'(rx_data); rv = rx_valid;
        dig = (b >= 48 && b <= 57);
        sep = (b == 32 || b == 13 || b == 10);
`ifdef MATRIX_PARSER_ECHO_EN
        old_full = h_full;
        if (old_full && !tx_busy && !e_tx_start) begin
            e_tx_data = h_byte; e_tx_start = 1; h_full = 0;
        end else e_tx_start = 0;
        if (rv && !old_full) begin h_byte = b; h_full = 1; end
`else
        old_full = 0;
`endif
        e_err = 0;
        if (m_commit) begin
            if (wr_if.wr_ready) m_writes++;
            if (wr_if.wr_ready || !enable) begin m_commit = 0; e_wr_en = 0; e_busy = 0; end
        end else if (m_active) begin
            if (!enable) begin
                m_active = 0; e_busy = 0; m_has = 0;
            end else if (rv) begin
                if (dig) begin
                    m_cur = m_cur * 10 + (b - 48);
                    if (m_cur > 8191) m_cur = 8191;
                    m_has = 1;
                end else if (sep) begin
                    if (m_has) begin model_token(m_cur); m_cur = 0; m_has = 0; end
                end else model_fail(3);
            end
        end else if (enable && rv && dig) begin
            foreach (m_data[k]) m_data[k] = 0;
            e_code = 0; e_busy = 1; m_active = 1; m_cur = b - 48; m_has = 1; m_tok = 0;
        end
    endtask

    function automatic logic [DB-1:0] model_vec();
        logic [DB-1:0] v = '0;
        for (int k = 0; k < 25; k++) v[k*DW +: DW] = DW'(m_data[k]);
        return v;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison plus DUT-side event tracking
    bit chk_en = 0;
    bit prev_wr_en = 0;
    int dut_rises = 0, dut_wr_cycles = 0, dut_errs = 0;
    logic [2:0] last_row, last_col;
    logic [DB-1:0] last_data, rise_data;
    logic [7:0] tx_q [$];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("wr_en", 256'(wr_if.wr_en), 256'(e_wr_en));
            check("busy", 256'(busy), 256'(e_busy));
            check("err", 256'(err), 256'(e_err));
            check("err_code", 256'(err_code), 256'(e_code));
            check("tx_start", 256'(tx_start), 256'(e_tx_start));
            check("tx_data", 256'(tx_data), 256'(e_tx_data));
            if (e_wr_en) begin
                check("wr_row", 256'(wr_if.wr_row), 256'(e_row));
                check("wr_col", 256'(wr_if.wr_col), 256'(e_col));
                check("wr_data", 256'(wr_if.wr_data), 256'(model_vec()));
            end
            if (err) dut_errs++;
            if (wr_if.wr_en) begin
                dut_wr_cycles++;
                if (!prev_wr_en) begin dut_rises++; rise_data = wr_if.wr_data; end
                last_row = wr_if.wr_row; last_col = wr_if.wr_col; last_data = wr_if.wr_data;
            end
            if (tx_start) tx_q.push_back(tx_data);
            prev_wr_en = wr_if.wr_en;
        end
    end

    int ready_mode = 0;
    initial begin
        wr_if.wr_ready = 1'b0;
        forever begin
            @(negedge clk); #1;
            case (ready_mode)
                0:       wr_if.wr_ready = 1'b1;
                1:       wr_if.wr_ready = 1'($urandom_range(0, 1));
                default: wr_if.wr_ready = 1'b0;
            endcase
        end
    end

    int gap = 0;

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_num(input int v);
        send_str($sformatf("%0d", v));
    endtask

    task automatic send_sep();
        int n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++)
            case ($urandom_range(0, 2))
                0:       send_byte(8'h20);
                1:       send_byte(8'h0D);
                default: send_byte(8'h0A);
            endcase
    endtask

    task automatic wait_wr_low(input string name, input int budget);
        int n = 0;
        while (wr_if.wr_en && n < budget) begin tick(); n++; end
        check(name, 256'(wr_if.wr_en), 256'(0));
    endtask

    task automatic rand_matrix();
        int r, c, inj, v;
        r = $urandom_range(1, 5); c = $urandom_range(1, 5);
        inj = $urandom_range(0, 7);
        gap = $urandom_range(0, 2);
        if ($urandom_range(0, 3) == 0) send_sep();
        if (inj == 1) begin
            send_num(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 40));
            send_sep();
            return;
        end
        send_num(r); send_sep(); send_num(c); send_sep();
        if (inj == 3) begin send_byte(($urandom_range(0, 1) == 0) ? 8'h78 : 8'h2D); return; end
        for (int k = 0; k < r * c; k++) begin
            if (inj == 2 && k == r * c - 1) v = $urandom_range(512, 20000);
            else if ($urandom_range(0, 5) == 0) v = ($urandom_range(0, 1) == 0) ? 0 : 511;
            else v = $urandom_range(0, 511);
            send_num(v); send_sep();
        end
        wait_wr_low("rand_accept_timeout", 400);
    endtask

    int r0, e0, c0, w0;
    logic [DB-1:0] exp_v;

    initial begin
        model_reset();
        m_writes = 0;
        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_en", 256'(wr_if.wr_en), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_err_code", 256'(err_code), 256'(0));
        check("rst_wr_data", 256'(wr_if.wr_data), 256'(0));
        check("rst_tx_start", 256'(tx_start), 256'(0));
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Basic 2x3 write with zero-cycle acceptance
        r0 = dut_rises; c0 = dut_wr_cycles; w0 = m_writes;
        send_str("2 3 1 2 3 4 5 6\n");
        repeat (3) tick();
        exp_v = '0;
        for (int k = 0; k < 6; k++) exp_v[k*DW +: DW] = DW'(k + 1);
        check("t1_writes", 256'(dut_rises - r0), 256'(1));
        check("t1_wr_cycles", 256'(dut_wr_cycles - c0), 256'(1));
        check("t1_model_writes", 256'(m_writes - w0), 256'(1));
        check("t1_row", 256'(last_row), 256'(2));
        check("t1_col", 256'(last_col), 256'(3));
        check("t1_data", 256'(last_data), 256'(exp_v));
        check("t1_err_code", 256'(err_code), 256'(0));

        // Bad dimension, then recovery
        r0 = dut_rises; e0 = dut_errs;
        send_str("6 ");
        repeat (2) tick();
        check("t2_err_pulses", 256'(dut_errs - e0), 256'(1));
        check("t2_err_code", 256'(err_code), 256'(1));
        check("t2_no_write", 256'(dut_rises - r0), 256'(0));
        send_str("1 1 7 ");
        repeat (3) tick();
        check("t2_row", 256'(last_row), 256'(1));
        check("t2_col", 256'(last_col), 256'(1));
        check("t2_data", 256'(last_data), 256'(7));

        // Element overflow boundary
        r0 = dut_rises;
        send_str("1 1 512 ");
        repeat (2) tick();
        check("t3_err_code", 256'(err_code), 256'(2));
        check("t3_no_write", 256'(dut_rises - r0), 256'(0));
        send_str("1 1 511 ");
        repeat (3) tick();
        check("t3_data", 256'(last_data), 256'(511));

        // Illegal character, then separator runs
        r0 = dut_rises;
        send_str("2 2 1 x");
        repeat (2) tick();
        check("t4_err_code", 256'(err_code), 256'(3));
        check("t4_no_write", 256'(dut_rises - r0), 256'(0));
        send_str("  \r\n3 1 0 0 0\r\n");
        repeat (3) tick();
        check("t4_writes", 256'(dut_rises - r0), 256'(1));
        check("t4_row", 256'(last_row), 256'(3));
        check("t4_col", 256'(last_col), 256'(1));
        check("t4_data", 256'(last_data), 256'(0));

        // Back-pressure in COMMIT with bytes arriving
        ready_mode = 2;
        r0 = dut_rises; w0 = m_writes;
        send_str("1 2 8 9 ");
        send_str("9 9");
        repeat (7) tick();
        check("t5_held", 256'(wr_if.wr_en), 256'(1));
        check("t5_stable", 256'(last_data), 256'(rise_data));
        ready_mode = 0;
        wait_wr_low("t5_accept_timeout", 10);
        check("t5_writes", 256'(dut_rises - r0), 256'(1));
        check("t5_model_writes", 256'(m_writes - w0), 256'(1));
        send_str("2 1 3 4 ");
        repeat (3) tick();
        exp_v = '0; exp_v[DW-1:0] = DW'(3); exp_v[2*DW-1:DW] = DW'(4);
        check("t5_next_data", 256'(last_data), 256'(exp_v));

        // Enable drop and mid-operation reset
        r0 = dut_rises; e0 = dut_errs;
        send_str("2 2 5");
        enable = 1'b0;
        repeat (2) tick();
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_err", 256'(dut_errs - e0), 256'(0));
        check("t6_no_write", 256'(dut_rises - r0), 256'(0));
        enable = 1'b1;
        send_str("2 2 4");
        rst_n = 1'b0;
        tick();
        check("t6_rst_busy", 256'(busy), 256'(0));
        check("t6_rst_wr_data", 256'(wr_if.wr_data), 256'(0));
        check("t6_rst_err_code", 256'(err_code), 256'(0));
        rst_n = 1'b1;
        tick();
        check("t6_rst_no_write", 256'(dut_rises - r0), 256'(0));

        // Randomized traffic
        r0 = dut_rises; w0 = m_writes;
        for (int i = 0; i < 60; i++) begin
            ready_mode = $urandom_range(0, 1);
            rand_matrix();
        end
        ready_mode = 0;
        repeat (4) tick();
        check("rand_write_count", 256'(dut_rises - r0), 256'(m_writes - w0));

`ifdef MATRIX_PARSER_ECHO_EN
        tx_q.delete();
        gap = 2;
        send_str("12 ");
        repeat (4) tick();
        check("echo_count", 256'(tx_q.size()), 256'(3));
        if (tx_q.size() == 3) begin
            check("echo_0", 256'(tx_q[0]), 256'(8'h31));
            check("echo_1", 256'(tx_q[1]), 256'(8'h32));
            check("echo_2", 256'(tx_q[2]), 256'(8'h20));
        end
`endif

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
